tenths_display_driver: RTL and testbench

Downstream consumer of the tenth-second counter's 14-bit count. It converts the binary count of tenths of a second to four BCD digits with an iterative double-dabble engine. It drives a 4-digit, time-multiplexed, active-low 7-segment display formatted as `XXX.X`, with leading-zero blanking and an overflow indication.

---
 rtl/tenths_display_driver_if.sv | 11 +
 rtl/tenths_display_driver.sv | 139 +++++++++++++
 tb/tb_tenths_display_driver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tenths_display_driver_if.sv
// Display-side bundle of tenths_display_driver: binary count in,
// multiplexed 7-segment drive and conversion strobe out.
interface tenths_display_driver_if;
  logic [13:0] value;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic        conv_done;

  modport master (output value, input seg, sel, conv_done);
  modport slave  (input value, output seg, sel, conv_done);
endinterface

// File: rtl/tenths_display_driver.sv
// Binary tenths-of-a-second count to a 4-digit multiplexed active-low
// 7-segment display (XXX.X) via an iterative double-dabble converter.
module tenths_display_driver #(
  parameter int unsigned SCAN_TICKS = 100_000
) (
  input logic clk,
  input logic rst,
  tenths_display_driver_if.slave dsp
);

  localparam int unsigned TW = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;

  typedef enum logic [1:0] {CAPTURE, SHIFT, COMMIT} state_e;

  state_e        state_q, state_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [15:0]   adj;
  logic [3:0]    cnt_q, cnt_d;
  logic          big_q, big_d;
  logic [15:0]   dig_q, dig_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    cur_digit;
  logic          blank;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CAPTURE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      big_q   <= 1'b0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= '0;
      idx_q   <= '0;
      sel_q   <= '1;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      big_q   <= big_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  // Overflow is judged on the captured value, since the 16-bit BCD
  // accumulator cannot hold a fifth digit.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    big_d   = big_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    adj     = bcd_q;
    case (state_q)
      CAPTURE: begin
        bin_d   = dsp.value;
        bcd_d   = '0;
        cnt_d   = '0;
        big_d   = (dsp.value >= 14'd10000);
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = COMMIT;
      end
      COMMIT: begin
        ovf_d = big_q;
        if (!big_q) dig_d = bcd_q;
        done_d  = 1'b1;
        state_d = CAPTURE;
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_comb begin
    tick_d = tick_q + TW'(1);
    idx_d  = idx_q;
    if (tick_q == TW'(SCAN_TICKS - 1)) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  always_comb begin
    cur_digit = dig_q[{idx_q, 2'b00} +: 4];
    blank     = ((idx_q == 2'd3) && (dig_q[15:12] == 4'd0)) ||
                ((idx_q == 2'd2) && (dig_q[15:8] == 8'd0));
    sel_d     = ~(4'b0001 << idx_q);
    seg_d[7]  = ~((idx_q == 2'd1) && !ovf_q);
    if (ovf_q)      seg_d[6:0] = 7'h3F;
    else if (blank) seg_d[6:0] = 7'h7F;
    else            seg_d[6:0] = glyph(cur_digit);
  end

  assign dsp.seg       = seg_q;
  assign dsp.sel       = sel_q;
  assign dsp.conv_done = done_q;

endmodule

// File: tb/tb_tenths_display_driver.sv
// Scoreboard bench for tenths_display_driver: stimulus queues captured
// values, a negedge monitor checks sel/seg/conv_done against a decimal model.
module tb_tenths_display_driver;

  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tenths_display_driver_if dif();

  tenths_display_driver #(.SCAN_TICKS(S)) dut (
    .clk (clk),
    .rst (rst),
    .dsp (dif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;     // rising edges since reset release
  bit in_rst   = 1'b1;
  int sb_q[$];
  bit m_ovf    = 1'b0;
  int m_disp   = 0;

  logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int i);
    int p;
    int dg;
    logic dp;
    if (m_ovf) return 8'hBF;
    if ((i == 3 && m_disp < 1000) || (i == 2 && m_disp < 100)) return 8'hFF;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    dg = (m_disp / p) % 10;
    dp = (i == 1) ? 1'b0 : 1'b1;
    return {dp, glyph_tab[dg]};
  endfunction

  // Monitor: checks the present outputs, then applies any commit seen
  // this cycle so it affects the following cycle's segments.
  always @(negedge clk) begin
    int idx;
    int v;
    logic [3:0] es;
    if (!in_rst && k >= 1) begin
      idx = ((k - 1) / S) % 4;
      es  = ~(4'b0001 << idx);
      chk("sel", int'(dif.sel), int'(es));
      chk("conv_done", int'(dif.conv_done), (k % 16 == 0) ? 1 : 0);
      chk("seg", int'(dif.seg), int'(exp_seg(idx)));
      if (dif.conv_done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got conv_done with no queued capture (k=%0d)", k);
        end else begin
          v = sb_q.pop_front();
          m_ovf = (v >= 10000);
          if (!m_ovf) m_disp = v;
        end
      end
    end
  end

  task automatic step(input int v);
    @(posedge clk);
    if (!in_rst) begin
      k++;
      if ((k - 1) % 16 == 0) sb_q.push_back(int'(dif.value));
    end
    #1 dif.value = v[13:0];
  endtask

  task automatic hold(input int v, input int n);
    repeat (n) step(v);
  endtask

  task automatic frame(input int v, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3);
    repeat (4 * S) begin
      step(v);
      @(negedge clk);
      case (dif.sel)
        4'b1110: chk("frame_d0", int'(dif.seg), int'(e0));
        4'b1101: chk("frame_d1", int'(dif.seg), int'(e1));
        4'b1011: chk("frame_d2", int'(dif.seg), int'(e2));
        4'b0111: chk("frame_d3", int'(dif.seg), int'(e3));
        default: chk("frame_sel", int'(dif.sel), 4'hE);
      endcase
    end
  endtask

  task automatic directed(input int v, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    hold(v, 34);
    frame(v, e0, e1, e2, e3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    int v;
    dif.value = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", int'(dif.seg), 8'hFF);
    chk("rst_sel", int'(dif.sel), 4'hF);
    chk("rst_done", int'(dif.conv_done), 0);
    rst = 1'b0;
    k = 0;
    in_rst = 1'b0;

    directed(0,     8'hC0, 8'h40, 8'hFF, 8'hFF);
    directed(1234,  8'h99, 8'h30, 8'hA4, 8'hF9);
    directed(9999,  8'h90, 8'h10, 8'h90, 8'h90);
    directed(10000, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    directed(16383, 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    directed(5,     8'h92, 8'h40, 8'hFF, 8'hFF);

    repeat (400) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       v = int'($urandom_range(0, 99));
        1:       v = int'($urandom_range(0, 999));
        2:       v = int'($urandom_range(0, 9999));
        default: v = int'($urandom_range(0, 16383));
      endcase
      step(v);
    end

    // Reset landing after the 7th shift edge of a conversion.
    while (k % 16 != 8) step(int'($urandom_range(0, 16383)));
    #2 rst = 1'b1;
    in_rst = 1'b1;
    #1;
    chk("async_rst_seg", int'(dif.seg), 8'hFF);
    chk("async_rst_sel", int'(dif.sel), 4'hF);
    chk("async_rst_done", int'(dif.conv_done), 0);
    sb_q.delete();
    m_ovf = 1'b0;
    m_disp = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_done", int'(dif.conv_done), 0);
    rst = 1'b0;
    k = 0;
    in_rst = 1'b0;

    directed(777, 8'hF8, 8'h78, 8'hF8, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
